instr_encode_loader: RTL and testbench

//  Field-level instruction encoder and imem loader, the inverse of the control-unit decode path.
//  - Accepts commands over a valid/ready handshake and encodes each into an RV32I word.
//  - Buffers encoded words in a small FIFO and streams them into instruction memory through its write port.
//  - Supported subset: lw, sw, R-type ALU, I-type ALU, beq.
//  - Used for boot-time program load and for self-checking tests of the single-cycle core.

---
 rtl/rv_isa_pkg.sv | 108 ++++++++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/instr_encode_loader.sv | 116 +++++++++++
 tb/tb_instr_encode_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions for the instruction encoder/loader and the decoders.
// Holds opcode, funct3/funct7 and ALUControl constants, the command-kind enum,
// the loader FSM state type and the field-level encoder function.
package rv_isa_pkg;

    // Major opcodes of the supported subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUControl codes, identical to the control-unit decode
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // funct3 / funct7 fields
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ITYPE = 3'd4
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } load_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    // Encode one command; legal=0 means the command must be dropped.
    function automatic enc_t encode_cmd(
        input logic [2:0]  kind,
        input logic [2:0]  alu,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        enc_t       res;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       alu_ok;
        res    = '{legal: 1'b0, word: 32'd0};
        f3     = F3_ADD_SUB;
        f7     = F7_BASE;
        alu_ok = 1'b1;
        case (alu)
            ALU_ADD: f3 = F3_ADD_SUB;
            ALU_SUB: begin
                f3 = F3_ADD_SUB;
                f7 = F7_SUB;
            end
            ALU_AND: f3 = F3_AND;
            ALU_OR:  f3 = F3_OR;
            ALU_SLT: f3 = F3_SLT;
            default: alu_ok = 1'b0;
        endcase
        case (kind)
            KIND_LW: begin
                res.word  = {imm, rs1, F3_WORD, rd, OP_LOAD};
                res.legal = alu_ok;
            end
            KIND_SW: begin
                res.word  = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
                res.legal = alu_ok;
            end
            KIND_RTYPE: begin
                res.word  = {f7, rs2, rs1, f3, rd, OP_R};
                res.legal = alu_ok;
            end
            KIND_ITYPE: begin
                // There is no subtract-immediate in RV32I
                res.word  = {imm, rs1, f3, rd, OP_I};
                res.legal = alu_ok && (alu != ALU_SUB);
            end
            KIND_BEQ: begin
                // imm holds offset[12:1], so imm[11] is offset bit 12
                res.word  = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OP_BRANCH};
                res.legal = alu_ok;
            end
            default: begin
                res.word  = 32'd0;
                res.legal = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers.
// Ports: clk, rst (async active-high), push/wdata (write side, caller must
// respect full), pop/rdata (read side, rdata is the head entry, show-ahead),
// full/empty status derived from the pointer registers only.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign rdata = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Storage array, cleared on reset so the head is never undefined
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encoder and imem loader.
// Commands (cmd_*) arrive on a valid/ready handshake, are encoded to RV32I
// words and queued; the queue head is streamed to imem (imem_we/addr/wdata,
// imem_ready handshake). cmd_err pulses for a dropped illegal command,
// load_done rises after the program's last word, words_loaded counts writes.
module instr_encode_loader
    import rv_isa_pkg::*;
#(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_kind,
    input  logic [2:0]            cmd_alu,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_rs1,
    input  logic [4:0]            cmd_rs2,
    input  logic [11:0]           cmd_imm,
    input  logic                  cmd_last,
    output logic                  cmd_err,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  imem_ready,
    output logic                  load_done,
    output logic [15:0]           words_loaded
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(3'd4);

    load_state_e           state_r;
    load_state_e           state_s;
    enc_t                  enc_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  write_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [32:0]           fifo_rdata_s;
    logic                  head_last_s;
    logic                  err_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [15:0]           count_r;

    assign cmd_ready    = !fifo_full_s && (state_r == ST_LOAD);
    assign accept_s     = cmd_valid && cmd_ready;
    assign enc_s        = encode_cmd(cmd_kind, cmd_alu, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
    assign push_s       = accept_s && enc_s.legal;
    assign imem_we      = !fifo_empty_s && (state_r != ST_DONE);
    assign write_s      = imem_we && imem_ready;
    assign head_last_s  = fifo_rdata_s[32];
    assign imem_wdata   = fifo_rdata_s[31:0];
    assign imem_addr    = addr_r;
    assign cmd_err      = err_r;
    assign load_done    = (state_r == ST_DONE);
    assign words_loaded = count_r;

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({cmd_last, enc_s.word}),
        .pop   (write_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic of the load sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && cmd_last) state_s = ST_DRAIN;
                else                      state_s = ST_LOAD;
            end
            ST_DRAIN: begin
                // Either the last-flagged word is being written now, or the
                // last command was illegal and nothing is left in the queue.
                if (fifo_empty_s)               state_s = ST_DONE;
                else if (write_s && head_last_s) state_s = ST_DONE;
                else                            state_s = ST_DRAIN;
            end
            ST_DONE:  state_s = ST_DONE;
            default:  state_s = ST_LOAD;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_LOAD;
        else     state_r <= state_s;
    end

    // Error pulse, write address and saturating write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r   <= 1'b0;
            addr_r  <= BASE_ADDR;
            count_r <= 16'd0;
        end else begin
            err_r <= accept_s && !enc_s.legal;
            if (write_s) begin
                addr_r <= addr_r + ADDR_STEP;
                if (count_r != 16'hFFFF) count_r <= count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_kind = 3'd0;
    logic [2:0]  cmd_alu = 3'd0;
    logic [4:0]  cmd_rd = 5'd0;
    logic [4:0]  cmd_rs1 = 5'd0;
    logic [4:0]  cmd_rs2 = 5'd0;
    logic [11:0] cmd_imm = 12'd0;
    logic        cmd_last = 1'b0;
    logic        cmd_err;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready = 1'b1;
    logic        load_done;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fails  = 0;

    instr_encode_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kind     (cmd_kind),
        .cmd_alu      (cmd_alu),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .cmd_last     (cmd_last),
        .cmd_err      (cmd_err),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_ready   (imem_ready),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one command and wait (bounded) for it to be accepted
    task automatic send(input logic [2:0] kind, input logic [2:0] alu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                        input logic last);
        logic got;
        got = 1'b0;
        cmd_kind = kind; cmd_alu = alu; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_last = last;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            got = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_last = 1'b0;
        if (!got) chk("send_timeout", {31'd0, got}, 32'd1);
    endtask

    // Wait (bounded) for a write strobe, check it, let it complete
    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (imem_we === 1'b1) begin
                seen = 1'b1;
                chk({tag, "_addr"}, imem_addr, addr);
                chk({tag, "_data"}, imem_wdata, data);
            end
            tick();
        end
        if (!seen) chk({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    logic [2:0]  k_t [6];
    logic [2:0]  a_t [6];
    logic [4:0]  rd_t [6];
    logic [4:0]  r1_t [6];
    logic [4:0]  r2_t [6];
    logic [11:0] im_t [6];
    logic [31:0] w_t [6];
    int          acc;
    logic        rdy;
    logic        flag;

    initial begin
        // Stall-test program: addi x1,x0,5 / and x4,x1,x2 / or x6,x1,x2 /
        // slti x7,x1,-1 / sub x3,x1,x2 / lw x5,8(x0)
        k_t[0] = 3'd4; a_t[0] = 3'b000; rd_t[0] = 5'd1; r1_t[0] = 5'd0; r2_t[0] = 5'd0; im_t[0] = 12'd5;   w_t[0] = 32'h00500093;
        k_t[1] = 3'd2; a_t[1] = 3'b010; rd_t[1] = 5'd4; r1_t[1] = 5'd1; r2_t[1] = 5'd2; im_t[1] = 12'd0;   w_t[1] = 32'h0020F233;
        k_t[2] = 3'd2; a_t[2] = 3'b011; rd_t[2] = 5'd6; r1_t[2] = 5'd1; r2_t[2] = 5'd2; im_t[2] = 12'd0;   w_t[2] = 32'h0020E333;
        k_t[3] = 3'd4; a_t[3] = 3'b101; rd_t[3] = 5'd7; r1_t[3] = 5'd1; r2_t[3] = 5'd0; im_t[3] = 12'hFFF; w_t[3] = 32'hFFF0A393;
        k_t[4] = 3'd2; a_t[4] = 3'b001; rd_t[4] = 5'd3; r1_t[4] = 5'd1; r2_t[4] = 5'd2; im_t[4] = 12'd0;   w_t[4] = 32'h402081B3;
        k_t[5] = 3'd0; a_t[5] = 3'b000; rd_t[5] = 5'd5; r1_t[5] = 5'd0; r2_t[5] = 5'd0; im_t[5] = 12'd8;   w_t[5] = 32'h00802283;

        // Reset values
        rst = 1'b1;
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_count", {16'd0, words_loaded}, 32'd0);
        chk("rst_err", {31'd0, cmd_err}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: sub x3,x1,x2
        imem_ready = 1'b1;
        chk("t1_we_idle", {31'd0, imem_we}, 32'd0);
        send(3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        chk("t1_we_after_accept", {31'd0, imem_we}, 32'd1);
        expect_write("t1", 32'd0, 32'h402081B3);
        chk("t1_count", {16'd0, words_loaded}, 32'd1);
        chk("t1_we_drained", {31'd0, imem_we}, 32'd0);

        // 2: lw x5,8(x0); sw x5,12(x0) last
        do_reset();
        imem_ready = 1'b0;
        send(3'd0, 3'b000, 5'd5, 5'd0, 5'd0, 12'd8, 1'b0);
        send(3'd1, 3'b000, 5'd0, 5'd0, 5'd5, 12'd12, 1'b1);
        chk("t2_ready_drain", {31'd0, cmd_ready}, 32'd0);
        imem_ready = 1'b1;
        expect_write("t2_lw", 32'd0, 32'h00802283);
        chk("t2_done_early", {31'd0, load_done}, 32'd0);
        expect_write("t2_sw", 32'd4, 32'h00502623);
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_count", {16'd0, words_loaded}, 32'd2);
        chk("t2_done_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t2_done_we", {31'd0, imem_we}, 32'd0);

        // 3: beq x1,x2,-8
        do_reset();
        send(3'd3, 3'b000, 5'd0, 5'd1, 5'd2, 12'hFFC, 1'b1);
        expect_write("t3", 32'd0, 32'hFE208CE3);
        chk("t3_done", {31'd0, load_done}, 32'd1);

        // 4: back-pressure, exactly DEPTH accepted, head held stable
        do_reset();
        imem_ready = 1'b0;
        acc = 0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cmd_kind = k_t[acc]; cmd_alu = a_t[acc]; cmd_rd = rd_t[acc];
            cmd_rs1 = r1_t[acc]; cmd_rs2 = r2_t[acc]; cmd_imm = im_t[acc]; cmd_last = 1'b0;
            rdy = cmd_ready;
            tick();
            if (rdy) acc++;
            if (c == 3 || c == 9) begin
                chk("t4_hold_addr", imem_addr, 32'd0);
                chk("t4_hold_data", imem_wdata, w_t[0]);
            end
        end
        cmd_valid = 1'b0;
        chk("t4_accepted", acc, 32'd4);
        chk("t4_ready_full", {31'd0, cmd_ready}, 32'd0);
        chk("t4_count_stall", {16'd0, words_loaded}, 32'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_write("t4_w", 32'(i * 4), w_t[i]);
        imem_ready = 1'b0;
        send(k_t[4], a_t[4], rd_t[4], r1_t[4], r2_t[4], im_t[4], 1'b0);
        send(k_t[5], a_t[5], rd_t[5], r1_t[5], r2_t[5], im_t[5], 1'b1);
        imem_ready = 1'b1;
        expect_write("t4_w4", 32'd16, w_t[4]);
        expect_write("t4_w5", 32'd20, w_t[5]);
        chk("t4_count", {16'd0, words_loaded}, 32'd6);
        chk("t4_done", {31'd0, load_done}, 32'd1);

        // 5: illegal commands
        do_reset();
        send(3'd6, 3'b000, 5'd1, 5'd1, 5'd1, 12'd1, 1'b0);
        chk("t5_err_kind", {31'd0, cmd_err}, 32'd1);
        tick();
        chk("t5_err_clear", {31'd0, cmd_err}, 32'd0);
        send(3'd4, 3'b001, 5'd1, 5'd1, 5'd0, 12'd3, 1'b0);
        chk("t5_err_isub", {31'd0, cmd_err}, 32'd1);
        chk("t5_we", {31'd0, imem_we}, 32'd0);
        chk("t5_count", {16'd0, words_loaded}, 32'd0);
        // Illegal last command with nothing queued still finishes the load
        send(3'd7, 3'b000, 5'd0, 5'd0, 5'd0, 12'd0, 1'b1);
        flag = 1'b0;
        for (int i = 0; i < 10 && !flag; i++) begin
            flag = load_done;
            if (!flag) tick();
        end
        chk("t5_done_illegal_last", {31'd0, flag}, 32'd1);
        chk("t5_count_end", {16'd0, words_loaded}, 32'd0);

        // 6: asynchronous reset with 3 words queued
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(k_t[i], a_t[i], rd_t[i], r1_t[i], r2_t[i], im_t[i], 1'b0);
        chk("t6_we_before", {31'd0, imem_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_we_async", {31'd0, imem_we}, 32'd0);
        chk("t6_addr_async", imem_addr, 32'd0);
        tick();
        rst = 1'b0;
        chk("t6_count", {16'd0, words_loaded}, 32'd0);
        imem_ready = 1'b1;
        send(k_t[3], a_t[3], rd_t[3], r1_t[3], r2_t[3], im_t[3], 1'b0);
        expect_write("t6_first", 32'd0, w_t[3]);
        chk("t6_count_after", {16'd0, words_loaded}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
